// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings and controller state type for the sequential ALU.
// Imported by seq_alu and seq_alu_mul.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles,
// low WIDTH bits of the product presented combinationally alongside done.
module seq_alu_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic [WIDTH-1:0] acc_p0;

  // product includes the current iteration so the final step can be loaded on the done edge
  assign product = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign done    = running && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

  // ---- iteration stage ----
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p0  <= a;
      mplier_p0 <= b;
      acc_p0    <= '0;
    end else if (running) begin
      acc_p0    <= product;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with ready/valid handshakes and a registered result.
// Define SEQ_ALU_MUL_EN to build the iterative multiplier for opcode 1010.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluoperation,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, b, s);
    return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic signed [WIDTH-1:0] sa_p0;
  logic signed [WIDTH-1:0] sb_p0;
  logic        [SHW-1:0]   shamt_p0;
  logic        [WIDTH-1:0] sum_p0;
  logic        [WIDTH-1:0] diff_p0;
  logic        [WIDTH-1:0] alu_res_p0;
  logic                    alu_ovf_p0;
  logic                    accept;
  logic                    load_alu;

  assign sa_p0    = data1;
  assign sb_p0    = data2;
  assign shamt_p0 = data2[SHW-1:0];
  assign sum_p0   = data1 + data2;
  assign diff_p0  = data1 - data2;
  assign accept   = in_valid && in_ready;

  // ---- operand stage: single-cycle result ----
  always_comb begin
    alu_res_p0 = sum_p0;
    alu_ovf_p0 = add_ovf(data1, data2, sum_p0);
    case (aluoperation)
      OP_SUB: begin
        alu_res_p0 = diff_p0;
        alu_ovf_p0 = sub_ovf(data1, data2, diff_p0);
      end
      OP_AND: begin alu_res_p0 = data1 & data2; alu_ovf_p0 = 1'b0; end
      OP_OR:  begin alu_res_p0 = data1 | data2; alu_ovf_p0 = 1'b0; end
      OP_XOR: begin alu_res_p0 = data1 ^ data2; alu_ovf_p0 = 1'b0; end
      OP_SLL: begin alu_res_p0 = data1 << shamt_p0; alu_ovf_p0 = 1'b0; end
      OP_SRL: begin alu_res_p0 = data1 >> shamt_p0; alu_ovf_p0 = 1'b0; end
      OP_SRA: begin alu_res_p0 = sa_p0 >>> shamt_p0; alu_ovf_p0 = 1'b0; end
      OP_SLT: begin
        alu_res_p0 = {{(WIDTH-1){1'b0}}, (sa_p0 < sb_p0)};
        alu_ovf_p0 = 1'b0;
      end
      OP_SLTU: begin
        alu_res_p0 = {{(WIDTH-1){1'b0}}, (data1 < data2)};
        alu_ovf_p0 = 1'b0;
      end
      default: begin
        alu_res_p0 = sum_p0;
        alu_ovf_p0 = add_ovf(data1, data2, sum_p0);
      end
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  state_t           state;
  state_t           state_nx;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (data1),
    .b       (data2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && (aluoperation == OP_MUL)) begin
          mul_start = 1'b1;
          state_nx  = MUL;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (mul_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign load_alu = accept && (aluoperation != OP_MUL);
`else
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign in_ready    = !out_valid || out_ready;
  assign busy        = 1'b0;
  assign load_alu    = accept;
`endif

  // ---- result stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      result    <= alu_res_p0;
      overflow  <= alu_ovf_p0;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_product;
      overflow  <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized
// traffic against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;
  localparam longint MAXS = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W-1));

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   aluoperation;
  logic [W-1:0] data1;
  logic [W-1:0] data2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .aluoperation (aluoperation),
    .data1        (data1),
    .data2        (data2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .overflow     (overflow),
    .busy         (busy)
  );

  // Reference: returns {overflow, result} from plain integer arithmetic.
  function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s;
    logic [63:0] p;
    int sh;
    logic [W-1:0] r;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % W);
    ov = 1'b0;
    s  = sa + sb;
    r  = s[W-1:0];
    ov = (s > MAXS) || (s < MINS);
    case (op)
      4'd1: begin s = sa - sb; r = s[W-1:0]; ov = (s > MAXS) || (s < MINS); end
      4'd2: begin r = a & b; ov = 1'b0; end
      4'd3: begin r = a | b; ov = 1'b0; end
      4'd4: begin r = a ^ b; ov = 1'b0; end
      4'd5: begin p = 64'(a) << sh; r = p[W-1:0]; ov = 1'b0; end
      4'd6: begin r = a >> sh; ov = 1'b0; end
      4'd7: begin s = sa >>> sh; r = s[W-1:0]; ov = 1'b0; end
      4'd8: begin r = (sa < sb) ? 1 : 0; ov = 1'b0; end
      4'd9: begin r = (a < b) ? 1 : 0; ov = 1'b0; end
`ifdef SEQ_ALU_MUL_EN
      4'd10: begin p = 64'(a) * 64'(b); r = p[W-1:0]; ov = 1'b0; end
`endif
      default: ;
    endcase
    return {ov, r};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 1;
      2: return 32'h7fffffff;
      3: return 32'h80000000;
      4: return 32'hffffffff;
      default: return $urandom();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; aluoperation = 4'd0;
    data1 = 32'd5; data2 = 32'd6; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %0b want 1", zero); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [3:0]   t_op  [8] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd1, 4'd6, 4'd15};
    logic [W-1:0] t_a   [8] = '{32'h7fffffff, 32'h5, 32'h80000000, 32'hffffffff, 32'hffffffff, 32'h80000000, 32'h80000000, 32'd3};
    logic [W-1:0] t_b   [8] = '{32'h1, 32'h5, 32'h24, 32'h1, 32'h1, 32'h1, 32'h21, 32'd4};
    logic [W-1:0] t_r   [8] = '{32'h80000000, 32'h0, 32'hf8000000, 32'h1, 32'h0, 32'h7fffffff, 32'h40000000, 32'd7};
    logic         t_ov  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; aluoperation = t_op[i]; data1 = t_a[i]; data2 = t_b[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %0b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_out_valid got %0b want 1", i, out_valid); end
      checks++; if (result !== t_r[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, result, t_r[i]); end
      checks++; if (zero !== (t_r[i] == 0)) begin errors++; $display("FAIL dir%0d_zero got %0b want %0b", i, zero, (t_r[i] == 0)); end
      checks++; if (overflow !== t_ov[i]) begin errors++; $display("FAIL dir%0d_overflow got %0b want %0b", i, overflow, t_ov[i]); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [W:0] exp;
    logic [3:0] op;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
`ifdef SEQ_ALU_MUL_EN
      if (op == 4'd10) op = 4'd0;
`endif
      in_valid = 1'b1; aluoperation = op; data1 = pick(); data2 = pick();
      exp = ref_alu(op, data1, data2);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_in_ready got %0b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || result !== exp[W-1:0] || overflow !== exp[W] || zero !== (exp[W-1:0] == 0)) begin
        errors++;
        $display("FAIL rnd%0d op=%0d a=%h b=%h got v=%0b r=%h o=%0b z=%0b want v=1 r=%h o=%0b z=%0b",
                 i, op, data1, data2, out_valid, result, overflow, zero, exp[W-1:0], exp[W], (exp[W-1:0] == 0));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q[$];
    logic [W-1:0] want;
    int run = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; aluoperation = 4'd0; data1 = $urandom(); data2 = $urandom();
      q.push_back(data1 + data2);
      tick();
      want = q.pop_front();
      if (out_valid === 1'b1) run++;
      checks++; if (result !== want) begin errors++; $display("FAIL b2b%0d_result got %h want %h", i, result, want); end
    end
    in_valid = 1'b0;
    checks++; if (run !== 8) begin errors++; $display("FAIL b2b_valid_run got %0d want 8", run); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    int stable_bad = 0;
    int ready_bad = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; aluoperation = 4'd4; data1 = 32'hdeadbeef; data2 = 32'h12345678;
    held = 32'hdeadbeef ^ 32'h12345678;
    tick();
    aluoperation = 4'd0; data1 = 32'd100; data2 = 32'd23;
    for (int i = 0; i < 5; i++) begin
      if (result !== held || out_valid !== 1'b1) stable_bad++;
      if (in_ready !== 1'b0) ready_bad++;
      tick();
    end
    checks++; if (stable_bad !== 0) begin errors++; $display("FAIL bp_hold_result bad_cycles %0d want 0 (result %h want %h)", stable_bad, result, held); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL bp_in_ready_low bad_cycles %0d want 0", ready_bad); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (result !== 32'd123 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_result got %h v=%0b want 0000007b v=1", result, out_valid); end
    tick();
  endtask

  task automatic test_mul();
`ifdef SEQ_ALU_MUL_EN
    int lat;
    int busy_cycles;
    int rdy_seen;
    logic [W:0] exp;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1; aluoperation = 4'd10;
      if (n == 0) begin data1 = 32'h0000ffff; data2 = 32'h00010001; end
      else begin data1 = pick(); data2 = pick(); end
      exp = ref_alu(4'd10, data1, data2);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul%0d_in_ready got %0b want 1", n, in_ready); end
      tick();
      in_valid = 1'b0;
      lat = 1; busy_cycles = 0; rdy_seen = 0;
      while (out_valid !== 1'b1 && lat < 60) begin
        if (busy === 1'b1) busy_cycles++;
        if (in_ready !== 1'b0) rdy_seen++;
        tick();
        lat++;
      end
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL mul%0d_latency got %0d want %0d", n, lat, W + 1); end
      checks++; if (busy_cycles !== W) begin errors++; $display("FAIL mul%0d_busy_cycles got %0d want %0d", n, busy_cycles, W); end
      checks++; if (rdy_seen !== 0) begin errors++; $display("FAIL mul%0d_in_ready_during got %0d want 0", n, rdy_seen); end
      checks++; if (result !== exp[W-1:0] || overflow !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mul%0d_result got %h o=%0b b=%0b want %h o=0 b=0", n, result, overflow, busy, exp[W-1:0]);
      end
      tick();
    end
`else
    out_ready = 1'b1;
    in_valid = 1'b1; aluoperation = 4'd10; data1 = 32'h7fffffff; data2 = 32'h00000002;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'h80000001 || overflow !== 1'b1) begin
      errors++; $display("FAIL op10_as_add got v=%0b r=%h o=%0b want v=1 r=80000001 o=1", out_valid, result, overflow);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL op10_busy got %0b want 0", busy); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_op();
    int late = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; data1 = 32'd3; data2 = 32'd5;
`ifdef SEQ_ALU_MUL_EN
    aluoperation = 4'd10;
`else
    aluoperation = 4'd0;
`endif
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
      errors++; $display("FAIL rst_mid got v=%0b b=%0b z=%0b want v=0 b=0 z=1", out_valid, busy, zero);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) late++;
      tick();
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL rst_no_late_result got %0d valid cycles want 0", late); end
    in_valid = 1'b1; aluoperation = 4'd0; data1 = 32'd2; data2 = 32'd3;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd5) begin errors++; $display("FAIL rst_then_add got v=%0b r=%h want v=1 r=00000005", out_valid, result); end
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; aluoperation = '0;
    data1 = '0; data2 = '0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_mul();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
